// File: rtl/key_event_if.sv
// Signal bundle between the key event classifier and its consumer.
// The slave side is the classifier: it receives key_in and drives every event output.
interface key_event_if;
  logic       key_in;
  logic       press_pulse;
  logic       release_pulse;
  logic       click_pulse;
  logic       long_pulse;
  logic       repeat_pulse;
  logic       held;
  logic [7:0] click_cnt;
  logic [1:0] state_dbg;

  modport master (
    output key_in,
    input  press_pulse, release_pulse, click_pulse, long_pulse,
           repeat_pulse, held, click_cnt, state_dbg
  );

  modport slave (
    input  key_in,
    output press_pulse, release_pulse, click_pulse, long_pulse,
           repeat_pulse, held, click_cnt, state_dbg
  );
endinterface

// File: rtl/key_event.sv
// Classifies a debounced key level into press/release/click/long/repeat events
// and keeps a wrapping click counter. Every output is registered.
module key_event #(
  parameter int LONG_CYC   = 15000,
  parameter int REPEAT_CYC = 3000,
  parameter int CNT_W      = 20
) (
  input  logic        clk,
  input  logic        rst_n,
  key_event_if.slave  bus
);
  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    PRESSED = 2'd1,
    LONG    = 2'd2
  } state_t;

  localparam logic [CNT_W-1:0] HOLD_LAST = CNT_W'(LONG_CYC - 1);
  localparam logic [CNT_W-1:0] REP_LAST  = CNT_W'(REPEAT_CYC - 1);
  localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);

  state_t           state;
  logic             key_d;
  logic             arm;
  logic [CNT_W-1:0] hold_cnt;
  logic [CNT_W-1:0] rep_cnt;
  logic [7:0]       click_cnt;
  logic             press_r, release_r, click_r, long_r, repeat_r, held_r;
  logic             rise;

  // arm stays low until the key is seen released, so a key held through reset is not a press
  assign rise = bus.key_in & ~key_d & arm;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      key_d     <= 1'b0;
      arm       <= 1'b0;
      hold_cnt  <= '0;
      rep_cnt   <= '0;
      click_cnt <= 8'd0;
      press_r   <= 1'b0;
      release_r <= 1'b0;
      click_r   <= 1'b0;
      long_r    <= 1'b0;
      repeat_r  <= 1'b0;
      held_r    <= 1'b0;
    end else begin
      key_d     <= bus.key_in;
      if (!bus.key_in) arm <= 1'b1;
      press_r   <= 1'b0;
      release_r <= 1'b0;
      click_r   <= 1'b0;
      long_r    <= 1'b0;
      repeat_r  <= 1'b0;
      case (state)
        IDLE: begin
          if (rise) begin
            press_r  <= 1'b1;
            hold_cnt <= '0;
            state    <= PRESSED;
          end
        end
        PRESSED: begin
          if (!bus.key_in) begin
            release_r <= 1'b1;
            click_r   <= 1'b1;
            click_cnt <= click_cnt + 8'd1;
            state     <= IDLE;
          end else if (hold_cnt == HOLD_LAST) begin
            long_r  <= 1'b1;
            rep_cnt <= '0;
            held_r  <= 1'b1;
            state   <= LONG;
          end else begin
            hold_cnt <= hold_cnt + CNT_ONE;
          end
        end
        LONG: begin
          if (!bus.key_in) begin
            release_r <= 1'b1;
            held_r    <= 1'b0;
            state     <= IDLE;
          end else if (rep_cnt == REP_LAST) begin
            repeat_r <= 1'b1;
            rep_cnt  <= '0;
          end else begin
            rep_cnt <= rep_cnt + CNT_ONE;
          end
        end
        default: begin
          state  <= IDLE;
          held_r <= 1'b0;
        end
      endcase
    end
  end

  assign bus.press_pulse   = press_r;
  assign bus.release_pulse = release_r;
  assign bus.click_pulse   = click_r;
  assign bus.long_pulse    = long_r;
  assign bus.repeat_pulse  = repeat_r;
  assign bus.held          = held_r;
  assign bus.click_cnt     = click_cnt;
  assign bus.state_dbg     = state;
endmodule

// File: tb/tb_key_event.sv
// Directed bench for key_event with LONG_CYC=8, REPEAT_CYC=3.
// Pulses are checked as a packed {press,release,click,long,repeat} vector.
module tb_key_event;
  logic clk;
  logic rst_n;
  int   n_checks;
  int   n_pass;
  int   n_clicks;
  logic [7:0] exp_q[$];
  logic [7:0] exp_cnt;

  key_event_if bus ();

  key_event #(.LONG_CYC(8), .REPEAT_CYC(3), .CNT_W(20)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  // clock/reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
  endtask

  // driver tasks
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [4:0] pulses();
    return {bus.press_pulse, bus.release_pulse, bus.click_pulse,
            bus.long_pulse, bus.repeat_pulse};
  endfunction

  task automatic do_reset();
    bus.key_in = 1'b0;
    rst_n = 1'b0;
    tick();
    tick();
    rst_n = 1'b1;
    tick();
    tick();
  endtask

  initial begin
    n_checks = 0;
    n_pass   = 0;
    rst_n    = 1'b0;
    bus.key_in = 1'b0;
    #1;
    check("reset_async_pulses", {27'd0, pulses()}, 32'd0);
    do_reset();
    check("reset_pulses", {27'd0, pulses()}, 32'd0);
    check("reset_held", {31'd0, bus.held}, 32'd0);
    check("reset_cnt", {24'd0, bus.click_cnt}, 32'd0);
    check("reset_state", {30'd0, bus.state_dbg}, 32'd0);

    // short press: high 4 cycles
    bus.key_in = 1'b1;
    tick();
    check("short_press", {27'd0, pulses()}, 32'b10000);
    for (int i = 1; i < 4; i++) begin
      tick();
      check("short_hold", {27'd0, pulses()}, 32'd0);
    end
    bus.key_in = 1'b0;
    tick();
    check("short_release", {27'd0, pulses()}, 32'b01100);
    check("short_cnt", {24'd0, bus.click_cnt}, 32'd1);
    check("short_held", {31'd0, bus.held}, 32'd0);
    tick();
    check("short_after", {27'd0, pulses()}, 32'd0);

    // long press: high 20 cycles, repeats at +11,+14,+17, release coincides with a repeat slot
    bus.key_in = 1'b1;
    tick();
    check("long_press", {27'd0, pulses()}, 32'b10000);
    for (int i = 1; i < 20; i++) begin
      tick();
      if (i == 8) check("long_pulse", {27'd0, pulses()}, 32'b00010);
      else if (i == 11 || i == 14 || i == 17) check("long_repeat", {27'd0, pulses()}, 32'b00001);
      else check("long_quiet", {27'd0, pulses()}, 32'd0);
      check("long_held", {31'd0, bus.held}, (i >= 8) ? 32'd1 : 32'd0);
    end
    check("long_state", {30'd0, bus.state_dbg}, 32'd2);
    bus.key_in = 1'b0;
    tick();
    check("long_release", {27'd0, pulses()}, 32'b01000);
    check("long_cnt", {24'd0, bus.click_cnt}, 32'd1);
    check("long_held_clr", {31'd0, bus.held}, 32'd0);

    // release exactly at the long threshold edge
    tick();
    bus.key_in = 1'b1;
    tick();
    check("thr_press", {27'd0, pulses()}, 32'b10000);
    for (int i = 1; i < 8; i++) tick();
    bus.key_in = 1'b0;
    tick();
    check("thr_release", {27'd0, pulses()}, 32'b01100);
    check("thr_cnt", {24'd0, bus.click_cnt}, 32'd2);
    check("thr_held", {31'd0, bus.held}, 32'd0);
    for (int i = 0; i < 4; i++) begin
      tick();
      check("thr_no_long", {27'd0, pulses()}, 32'd0);
    end

    // release coincident with the first repeat edge
    bus.key_in = 1'b1;
    tick();
    for (int i = 1; i < 11; i++) tick();
    check("rep_held", {31'd0, bus.held}, 32'd1);
    bus.key_in = 1'b0;
    tick();
    check("rep_release", {27'd0, pulses()}, 32'b01000);
    check("rep_state", {30'd0, bus.state_dbg}, 32'd0);
    check("rep_cnt", {24'd0, bus.click_cnt}, 32'd2);

    // 256 clicks from a fresh reset; scoreboard of expected counter values
    do_reset();
    n_clicks = 0;
    for (int i = 0; i < 256; i++) begin
      exp_cnt = 8'(i + 1);
      exp_q.push_back(exp_cnt);
      bus.key_in = 1'b1;
      tick();
      bus.key_in = 1'b0;
      tick();
      if (bus.click_pulse) begin
        n_clicks++;
        if (exp_q.size() > 0) check("wrap_cnt", {24'd0, bus.click_cnt}, {24'd0, exp_q.pop_front()});
      end
    end
    check("wrap_clicks", n_clicks, 32'd256);
    check("wrap_final", {24'd0, bus.click_cnt}, 32'd0);
    check("wrap_queue_empty", exp_q.size(), 32'd0);

    // reset in LONG with key held
    tick();
    bus.key_in = 1'b1;
    tick();
    for (int i = 1; i < 10; i++) tick();
    check("rst_pre_held", {31'd0, bus.held}, 32'd1);
    #2;
    rst_n = 1'b0;
    #1;
    check("rst_async_pulses", {27'd0, pulses()}, 32'd0);
    check("rst_async_held", {31'd0, bus.held}, 32'd0);
    check("rst_async_cnt", {24'd0, bus.click_cnt}, 32'd0);
    tick();
    rst_n = 1'b1;
    for (int i = 0; i < 5; i++) begin
      tick();
      check("rst_no_press", {27'd0, pulses()}, 32'd0);
      check("rst_idle", {30'd0, bus.state_dbg}, 32'd0);
    end
    bus.key_in = 1'b0;
    tick();
    tick();
    bus.key_in = 1'b1;
    tick();
    check("rst_repress", {27'd0, pulses()}, 32'b10000);
    tick();
    check("rst_repress_end", {27'd0, pulses()}, 32'd0);

    // final report
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule
